io_uart_receiver: RTL and testbench

- Memory-mapped UART receiver on the processor io bus (io_read_en / io_write_en / io_address / io_read_data).
- Deserializes 8N1 frames on uart_rx into a receive FIFO. Software polls a status register and pops bytes from a data register.
- Receive counterpart to the debug trace UART transmitter.
- Lets the host send commands and data to running code without JTAG reload.

---
 rtl/io_uart_receiver_pkg.sv | 33 +++
 rtl/io_uart_receiver_sync_fifo.sv | 56 +++++
 rtl/io_uart_receiver.sv | 178 +++++++++++++++++
 tb/tb_io_uart_receiver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_receiver_pkg.sv
// Shared register map, status bit positions and receiver FSM states for the
// memory-mapped UART receiver.
package io_uart_receiver_pkg;

  localparam logic [31:0] STATUS_OFFSET = 32'h0;
  localparam logic [31:0] DATA_OFFSET   = 32'h4;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  function automatic logic [31:0] pack_status(input logic       not_empty,
                                              input logic       overrun,
                                              input logic       frame_err,
                                              input logic [7:0] count);
    logic [31:0] s;
    s = '0;
    s[STAT_NOT_EMPTY] = not_empty;
    s[STAT_OVERRUN]   = overrun;
    s[STAT_FRAME_ERR] = frame_err;
    s[STAT_COUNT_LSB +: 8] = count;
    return s;
  endfunction

endpackage

// File: rtl/io_uart_receiver_sync_fifo.sv
// Single-clock FIFO; an enqueue is accepted when full if a dequeue happens in
// the same cycle, since the pop frees the slot being written.
module io_uart_receiver_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enqueue,
  input  logic                     dequeue,
  input  logic [WIDTH-1:0]         value_i,
  output logic [WIDTH-1:0]         value_o,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(SIZE):0]    count
);

  localparam int PTR_W = $clog2(SIZE);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_enq;
  logic             w_deq;

  assign empty   = (r_count == '0);
  assign full    = (r_count == (PTR_W+1)'(SIZE));
  assign count   = r_count;
  assign value_o = r_mem[r_rd_ptr];

  assign w_deq = dequeue && !empty;
  assign w_enq = enqueue && (!full || w_deq);

  // Pointers wrap naturally because SIZE is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= value_i;
  end

endmodule

// File: rtl/io_uart_receiver.sv
// 8N1 UART receiver on the io bus: synchronizes uart_rx, samples mid-bit,
// queues bytes in a FIFO and exposes status/data registers to software.
module io_uart_receiver
  import io_uart_receiver_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h18,
  parameter int          BAUD_DIVIDE  = 50000000 / 115200,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  input  logic        io_read_en,
  input  logic        io_write_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        rx_irq
);

  localparam int             CNT_W    = $clog2(BAUD_DIVIDE);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIVIDE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIVIDE - 1);
  localparam int             CNT_FIFO_W = $clog2(FIFO_DEPTH) + 1;

  rx_state_t        r_state;
  rx_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic             w_expire;
  logic             w_shift_en;
  logic             w_push;
  logic             w_frame_err_set;

  logic             r_rx_meta;
  logic             r_rx_s;
  logic [7:0]       r_shift;

  logic             r_overrun;
  logic             r_frame_err;
  logic [31:0]      r_read_data;

  logic             w_status_sel;
  logic             w_data_sel;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic [CNT_FIFO_W-1:0] w_count;
  logic             w_unused;

  assign w_unused = ^{io_write_data[31:3], io_write_data[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
    end
  end

  // The counter runs down to zero; zero marks the sampling point of a bit.
  assign w_expire = (r_cnt == '0);

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = w_expire ? r_cnt : r_cnt - 1'b1;
    w_bit_idx_next  = r_bit_idx;
    w_shift_en      = 1'b0;
    w_push          = 1'b0;
    w_frame_err_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_next = ST_START;
          w_cnt_next   = CNT_HALF;
        end
      end
      ST_START: begin
        if (w_expire) begin
          if (r_rx_s) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next   = ST_DATA;
            w_cnt_next     = CNT_FULL;
            w_bit_idx_next = '0;
          end
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          w_shift_en     = 1'b1;
          w_cnt_next     = CNT_FULL;
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_expire) begin
          w_push          = r_rx_s;
          w_frame_err_set = !r_rx_s;
          w_state_next    = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_shift_en) r_shift[r_bit_idx] <= r_rx_s;
  end

  io_uart_receiver_sync_fifo #(
    .WIDTH (8),
    .SIZE  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .enqueue (w_push),
    .dequeue (w_pop),
    .value_i (r_shift),
    .value_o (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign w_status_sel = (io_address == BASE_ADDRESS + STATUS_OFFSET);
  assign w_data_sel   = (io_address == BASE_ADDRESS + DATA_OFFSET);
  assign w_pop        = io_read_en && w_data_sel && !w_empty;

  // A same-cycle pop makes room, so only a push into a still-full FIFO overruns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop)
        r_overrun <= 1'b1;
      else if (io_write_en && w_status_sel && io_write_data[STAT_OVERRUN])
        r_overrun <= 1'b0;
      if (w_frame_err_set)
        r_frame_err <= 1'b1;
      else if (io_write_en && w_status_sel && io_write_data[STAT_FRAME_ERR])
        r_frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data <= '0;
    end else if (io_read_en && w_status_sel) begin
      r_read_data <= pack_status(!w_empty, r_overrun, r_frame_err, 8'(w_count));
    end else if (io_read_en && w_data_sel) begin
      r_read_data <= w_empty ? 32'h0 : {24'h0, w_head};
    end
  end

  assign io_read_data = r_read_data;
  assign rx_irq       = !w_empty || r_overrun || r_frame_err;

endmodule

// File: tb/tb_io_uart_receiver.sv
// Bench for io_uart_receiver: drives 8N1 frames and io bus accesses; a monitor
// checks every read against expected values queued by the stimulus.
module tb_io_uart_receiver;

  localparam int          BAUD   = 16;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] BASE   = 32'h18;
  localparam logic [31:0] STATUS = BASE;
  localparam logic [31:0] DATA   = BASE + 32'h4;

  logic        clk;
  logic        reset;
  logic        uart_rx;
  logic        io_read_en;
  logic        io_write_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        rx_irq;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  io_uart_receiver #(
    .BASE_ADDRESS (BASE),
    .BAUD_DIVIDE  (BAUD),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .io_read_en    (io_read_en),
    .io_write_en   (io_write_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .rx_irq        (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a read strobe seen at a rising edge means io_read_data is valid
  // from that edge on; compare it at the following falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (io_read_en === 1'b1) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_read: got 0x%08h, expected no read", io_read_data);
        end else begin
          chk(tag_q.pop_front(), io_read_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      uart_rx = f[i];
      repeat (BAUD) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, 10);
  endtask

  task automatic io_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    io_address = addr;
    io_read_en = 1'b1;
    @(negedge clk);
    io_read_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
    io_address    = addr;
    io_write_data = data;
    io_write_en   = 1'b1;
    @(negedge clk);
    io_write_en   = 1'b0;
    io_write_data = '0;
  endtask

  initial begin
    reset         = 1'b1;
    uart_rx       = 1'b1;
    io_read_en    = 1'b0;
    io_write_en   = 1'b0;
    io_address    = '0;
    io_write_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_read_data", io_read_data, 32'h0);
    chk("reset_irq", {31'h0, rx_irq}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Two bytes, status, held data on undecoded read, ignored data write, pops.
    send_byte(8'h55);
    send_byte(8'hA3);
    io_read(STATUS, 32'h0000_0201, "status_two_bytes");
    chk("irq_two_bytes", {31'h0, rx_irq}, 32'h1);
    io_read(BASE + 32'h8, 32'h0000_0201, "undecoded_read_holds");
    io_write(DATA, 32'hFFFF_FFFF);
    io_read(STATUS, 32'h0000_0201, "status_after_ignored");
    io_read(DATA, 32'h0000_0055, "data_0x55");
    io_read(DATA, 32'h0000_00A3, "data_0xA3");
    io_read(STATUS, 32'h0000_0000, "status_drained");

    // Stop bit low: frame error, nothing queued.
    send_frame(8'h7E, 1'b0, 10);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    io_read(STATUS, 32'h0000_0004, "status_frame_err");
    chk("irq_frame_err", {31'h0, rx_irq}, 32'h1);
    io_write(STATUS, 32'h4);
    chk("irq_ferr_cleared", {31'h0, rx_irq}, 32'h0);
    io_read(STATUS, 32'h0000_0000, "status_ferr_cleared");

    // Short glitch is rejected; a real frame afterwards still works.
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    io_read(STATUS, 32'h0000_0000, "status_glitch");
    chk("irq_glitch", {31'h0, rx_irq}, 32'h0);
    send_byte(8'h5A);
    io_read(DATA, 32'h0000_005A, "data_after_glitch");

    // Nine bytes into an eight-deep FIFO: overrun, first eight kept.
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    io_read(STATUS, 32'h0000_0803, "status_overrun");
    for (int i = 1; i <= 8; i++) io_read(DATA, 32'(i), $sformatf("data_fill_%0d", i));
    io_read(DATA, 32'h0000_0000, "data_empty");
    io_read(STATUS, 32'h0000_0002, "status_overrun_only");
    io_write(STATUS, 32'h2);
    io_read(STATUS, 32'h0000_0000, "status_overrun_cleared");

    // Full FIFO popped on the exact cycle the next stop bit pushes.
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    io_read(STATUS, 32'h0000_0801, "status_full");
    fork
      send_byte(8'h18);
      begin
        repeat (154) @(negedge clk);
        io_read(DATA, 32'h0000_0010, "data_pop_on_push");
      end
    join
    io_read(STATUS, 32'h0000_0801, "status_pop_push");
    for (int i = 1; i <= 8; i++)
      io_read(DATA, 32'h10 + 32'(i), $sformatf("data_after_pp_%0d", i));
    io_read(STATUS, 32'h0000_0000, "status_pp_drained");

    // Reset in the middle of data bit 4.
    send_frame(8'h0F, 1'b1, 5);
    uart_rx = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    io_read(STATUS, 32'h0000_0000, "status_after_reset");
    chk("irq_after_reset", {31'h0, rx_irq}, 32'h0);
    send_byte(8'hC3);
    io_read(STATUS, 32'h0000_0101, "status_c3");
    io_read(DATA, 32'h0000_00C3, "data_c3");

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
